// File: rtl/serial_pattern_tx.sv
// MSB-first serial frame transmitter with load/busy/done handshake.
// Optional trailing even-parity bit when SERIAL_TX_PARITY_EN is defined.
module serial_pattern_tx #(
    parameter int   WIDTH    = 8,
    parameter int   LW       = 4,
    parameter logic IDLE_BIT = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    input  logic [LW-1:0]    len,
    output logic             x,
    output logic             valid,
    output logic             busy,
    output logic             done,
    output logic [1:0]       fsm_state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_PAR   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Handshake: a frame request is accepted when load=1 is sampled while busy=0
    // (IDLE or DONE); valid marks cycles where x carries a frame bit.
    state_t           state, state_n;
    logic [WIDTH-1:0] shreg, shreg_n;
    logic [LW-1:0]    cnt, cnt_n;
    logic             par, par_n;
    logic             x_n, valid_n, busy_n, done_n;

    logic [LW-1:0]    eff_len;
    logic [LW-1:0]    shamt;
    logic [WIDTH-1:0] aligned;

    // Left-align the frame so bit len-1 lands in the MSB of the shifter.
    always_comb begin
        eff_len = (len > LW'(WIDTH)) ? LW'(WIDTH) : len;
        shamt   = LW'(WIDTH) - eff_len;
        aligned = data << shamt;
    end

    always_comb begin
        state_n = ST_IDLE;
        shreg_n = shreg;
        cnt_n   = cnt;
        par_n   = par;
        x_n     = IDLE_BIT;
        valid_n = 1'b0;
        busy_n  = 1'b0;
        done_n  = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (load) begin
                    if (eff_len == '0) begin
`ifdef SERIAL_TX_PARITY_EN
                        state_n = ST_PAR;
                        par_n   = 1'b0;
                        x_n     = 1'b0;
                        valid_n = 1'b1;
                        busy_n  = 1'b1;
`else
                        state_n = ST_DONE;
                        done_n  = 1'b1;
`endif
                    end else begin
                        state_n = ST_SHIFT;
                        x_n     = aligned[WIDTH-1];
                        par_n   = aligned[WIDTH-1];
                        shreg_n = aligned << 1;
                        cnt_n   = eff_len - LW'(1);
                        valid_n = 1'b1;
                        busy_n  = 1'b1;
                    end
                end
            end
            ST_SHIFT: begin
                // cnt counts bits still to send after the one currently on x
                if (cnt == '0) begin
`ifdef SERIAL_TX_PARITY_EN
                    state_n = ST_PAR;
                    x_n     = par;
                    valid_n = 1'b1;
                    busy_n  = 1'b1;
`else
                    state_n = ST_DONE;
                    done_n  = 1'b1;
`endif
                end else begin
                    state_n = ST_SHIFT;
                    x_n     = shreg[WIDTH-1];
                    par_n   = par ^ shreg[WIDTH-1];
                    shreg_n = shreg << 1;
                    cnt_n   = cnt - LW'(1);
                    valid_n = 1'b1;
                    busy_n  = 1'b1;
                end
            end
`ifdef SERIAL_TX_PARITY_EN
            ST_PAR: begin
                state_n = ST_DONE;
                done_n  = 1'b1;
            end
`endif
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
            shreg <= '0;
            cnt   <= '0;
            par   <= 1'b0;
            x     <= IDLE_BIT;
            valid <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            shreg <= shreg_n;
            cnt   <= cnt_n;
            par   <= par_n;
            x     <= x_n;
            valid <= valid_n;
            busy  <= busy_n;
            done  <= done_n;
        end
    end

    assign fsm_state = state;

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Scoreboard bench for serial_pattern_tx: directed frames, expected bits queued
// at load time and popped by a negedge monitor whenever valid or done is high.
module tb_serial_pattern_tx;

    logic       clk;
    logic       reset;
    logic       load;
    logic [7:0] data;
    logic [3:0] len;
    logic       x, valid, busy, done;
    logic [1:0] fsm_state;

    // entry: {is_done, bit}
    logic [1:0] exp_q[$];
    logic [1:0] mon_e;
    logic       mon_en;
    int         checks;
    int         failures;

    serial_pattern_tx #(.WIDTH(8), .LW(4), .IDLE_BIT(1'b1)) dut (
        .clk(clk), .reset(reset), .load(load), .data(data), .len(len),
        .x(x), .valid(valid), .busy(busy), .done(done), .fsm_state(fsm_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected-response model: clamp, MSB-first bits, optional parity, done marker.
    task automatic push_frame(input logic [7:0] d, input int l);
        int   n;
        logic p;
        n = (l > 8) ? 8 : l;
        p = 1'b0;
        for (int k = n - 1; k >= 0; k--) begin
            exp_q.push_back({1'b0, d[k]});
            p = p ^ d[k];
        end
`ifdef SERIAL_TX_PARITY_EN
        exp_q.push_back({1'b0, p});
`endif
        exp_q.push_back(2'b10);
    endtask

    // Called at a negedge; returns one negedge later with load dropped.
    task automatic send(input logic [7:0] d, input int l);
        data = d;
        len  = 4'(l);
        load = 1'b1;
        push_frame(d, l);
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (done !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL %s: done=%b after %0d cycles, required done=1", name, done, n);
        end
    endtask

    task automatic check_idle(input string name);
        checks++;
        if ({x, valid, busy, done} !== 4'b1000) begin
            failures++;
            $display("FAIL %s: x/valid/busy/done=%b%b%b%b required 1000", name, x, valid, busy, done);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if (busy !== valid) begin
                failures++;
                $display("FAIL busy_tracks_valid: busy=%b valid=%b", busy, valid);
            end
            if (valid === 1'b1 || done === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_output: valid=%b done=%b x=%b with empty queue", valid, done, x);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (valid === 1'b1 && done === 1'b1) begin
                        failures++;
                        $display("FAIL valid_and_done: both high, expected entry %b", mon_e);
                    end else if (valid === 1'b1) begin
                        if (mon_e[1] !== 1'b0 || x !== mon_e[0]) begin
                            failures++;
                            $display("FAIL frame_bit: got bit x=%b, expected entry %b", x, mon_e);
                        end
                    end else if (mon_e !== 2'b10) begin
                        failures++;
                        $display("FAIL done_marker: got done, expected entry %b", mon_e);
                    end
                end
            end else begin
                checks++;
                if (x !== 1'b1) begin
                    failures++;
                    $display("FAIL idle_line: x=%b required 1", x);
                end
            end
        end
    end

    initial begin
        checks   = 0;
        failures = 0;
        mon_en   = 1'b0;
        load     = 1'b0;
        data     = '0;
        len      = '0;
        reset    = 1'b1;
        #2 reset = 1'b0;

        repeat (2) begin
            @(negedge clk);
            check_idle("reset_hold");
        end
        reset = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_idle("after_reset");
        end
        mon_en = 1'b1;

        // Single frame: 0,0,1,0,0
        send(8'b0000_0100, 5);
        wait_done("single_done");
        @(negedge clk);
        check_idle("post_done_idle");

        // Back-to-back: second load issued during the done cycle
        send(8'h0F, 3);
        wait_done("b2b_first_done");
        send(8'hA5, 8);
        checks++;
        if (valid !== 1'b1 || done !== 1'b0 || x !== 1'b1) begin
            failures++;
            $display("FAIL b2b_start: valid=%b done=%b x=%b required 1 0 1", valid, done, x);
        end
        repeat (2) @(negedge clk);
        data = 8'hFF;
        len  = 4'd3;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        wait_done("b2b_second_done");
        @(negedge clk);

        // len=0
        send(8'hFF, 0);
        checks++;
`ifdef SERIAL_TX_PARITY_EN
        if (valid !== 1'b1 || x !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL len0_parity: valid=%b x=%b done=%b required 1 0 0", valid, x, done);
        end
`else
        if (done !== 1'b1 || valid !== 1'b0) begin
            failures++;
            $display("FAIL len0_done: done=%b valid=%b required 1 0", done, valid);
        end
`endif
        wait_done("len0_wait");
        @(negedge clk);

        // len=15 clamps to 8 bits
        send(8'hC3, 15);
        wait_done("len15_done");
        @(negedge clk);

        // 1,1,1 then parity 1 when enabled
        send(8'b0000_0111, 3);
        wait_done("parity_done");
        @(negedge clk);

        // Reset during bit 3 of a len=8 frame
        send(8'hA5, 8);
        repeat (3) @(negedge clk);
        #1 reset = 1'b0;
        #1 check_idle("reset_abort");
        exp_q.delete();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        send(8'b0000_0010, 2);
        wait_done("post_abort_done");
        @(negedge clk);
        check_idle("post_abort_idle");

        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL queue_drained: %0d entries left, required 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_pattern_tx.md
Name: serial_pattern_tx

Overview:
- Serial bit-pattern transmitter: loads a parallel word plus a bit count and shifts it out MSB-first, one bit per clock, on a single serial line.
- Drives the serial input of the team's bit-sequence detector FSMs, in benches and in-system.
- Provides load/busy/done handshaking so a controller can chain frames back-to-back.

Parameters:
- WIDTH, 8, maximum frame length in bits; data register width.
- LW, 4, width of len input; must satisfy 2^LW > WIDTH.
- IDLE_BIT, 1, value driven on x when no frame is in flight.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low reset.
- load  input  1  frame request; sampled on posedge clk when busy=0.
- data  input  WIDTH  frame bits; bit len-1 is sent first, bit 0 last.
- len  input  LW  number of bits to send.
- x  output  1  serial line (registered).
- valid  output  1  high while x carries a frame bit (registered).
- busy  output  1  high while a frame is in flight (registered).
- done  output  1  one-cycle pulse after the last bit (registered).

Behaviour:
- Reset (reset=0, async): state IDLE; x=IDLE_BIT, valid=0, busy=0, done=0; shift register and counter cleared.
- Reset asserted mid-frame aborts the frame immediately. No done pulse. Line returns to IDLE_BIT.
- States: IDLE, SHIFT, [PAR], DONE.
- IDLE:
  - load=0: stay IDLE.
  - load=1 and len in 1..WIDTH: capture data and len, go to SHIFT.
  - load=1 and len=0: go directly to DONE; no bits sent.
  - len>WIDTH: clamped to WIDTH.
- Latency: load sampled at edge t0. Bit data[len-1] appears on x, with valid=1 and busy=1, after edge t0.
  - Bit data[len-1-k] is driven after edge t0+k, for k=0..len-1.
- SHIFT: advance one bit per clock. After the final bit, go to DONE (or PAR if enabled). load is ignored while busy=1, with no queuing.
- DONE: single cycle; done=1, valid=0, busy=0, x=IDLE_BIT.
  - load=1 sampled in DONE is accepted exactly as in IDLE, so back-to-back frames are separated by exactly one idle (done) cycle.
  - Otherwise go to IDLE.
- Between frames x holds IDLE_BIT, so a downstream detector sees a continuous idle pattern.
- data/len changes while busy=1 have no effect on the frame in flight.
- Undefined state encoding: recover to IDLE on the next clock with idle outputs.

Optional Feature:
- Macro: SERIAL_TX_PARITY_EN.
- Defined: PAR state is inserted after the last data bit. For one cycle, x = XOR of all transmitted data bits (even parity), valid=1, busy=1. DONE follows. A len=0 frame sends a parity bit of 0.
- Undefined: no PAR state; SHIFT goes directly to DONE. Frame length is exactly len cycles.

Test Plan:
- Reset behaviour: hold reset=0 for 2 cycles, then release -> x=1, valid=0, busy=0, done=0 throughout. No activity until load.
- Single frame: load=1 for one cycle with data=8'b0000_0100, len=5 -> x = 0,0,1,0,0 on 5 consecutive cycles with valid=1 and busy=1, then done=1 for one cycle, then x=1 idle.
- Back-to-back frames: assert load in the done cycle with data=8'hA5, len=8 -> x = 1,0,1,0,0,1,0,1 starting the next cycle; load pulses during busy are ignored (frame unchanged).
- Boundary lengths:
  - len=0 -> done pulses the cycle after load, valid never high.
  - len=15 with WIDTH=8 -> exactly 8 bits are sent.
- Reset mid-frame: drop reset during bit 3 of a len=8 frame -> outputs go idle immediately. After release, a new load=1 with len=2 sends exactly 2 bits.
- Parity (SERIAL_TX_PARITY_EN defined): data=8'b0000_0111, len=3 -> x = 1,1,1, then parity bit 1, then done. With the macro undefined -> done directly after the third bit.
